// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI path: transfer FSM states,
// the SCLK half-period lengths used by the shifter and the init FSM,
// and small constant helpers used to size counters.
package sd_pkg;

    // Transfer engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sd_state_e;

    // SCLK half-periods in CLKin cycles (50 MHz in: ~390 kHz and 12.5 MHz out)
    localparam int SD_SLOW_HALF = 64;
    localparam int SD_FAST_HALF = 2;

    // Level driven on MOSI whenever no bit is being shifted
    localparam logic SD_IDLE_MOSI = 1'b1;

    // Index of the final bit of a byte
    localparam logic [2:0] SD_LAST_BIT = 3'd7;

    // Larger of two integers, for elaboration-time sizing
    function automatic int sd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0..n-1, never less than one
    function automatic int sd_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_sclk_tick.sv
// Half-period timer for the SPI clock. Counts CLKin cycles inside one
// SCLK half-period and flags the last cycle of it; the count wraps to
// zero on that cycle so consecutive halves run back to back.
module sd_sclk_tick
    import sd_pkg::*;
#(
    parameter int CNT_W = 6,
    parameter int LEN_W = CNT_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [LEN_W-1:0] half_len,
    output logic             last
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [LEN_W-1:0] half_m1_s;
    logic             last_s;

    // Terminal-count decode and next count (hold at zero while cleared)
    always_comb begin
        half_m1_s = half_len - LEN_ONE;
        last_s    = (LEN_W'(cnt_q) == half_m1_s);
        if (clear) begin
            cnt_d = CNT_ZERO;
        end else if (last_s) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Half-period counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = last_s & ~clear;

endmodule

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte engine for the SD card pins. Each accepted Start
// shifts TxByte out MSB-first on MOSI while sampling MISO on the rising
// SCLK edges, then presents the received byte with a one-cycle Done.
// SCLK is derived from CLKin with a per-transfer slow/fast half-period.
module sd_spi_shifter
    import sd_pkg::*;
#(
    parameter int SLOW_HALF = SD_SLOW_HALF,
    parameter int FAST_HALF = SD_FAST_HALF
) (
    input  logic       CLKin,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Slow,
    input  logic [7:0] TxByte,
    input  logic       MISO,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] RxByte,
    output logic       SCLK,
    output logic       MOSI
);

    localparam int HALF_MAX = sd_max(SLOW_HALF, FAST_HALF);
    localparam int CNT_W    = sd_cnt_w(HALF_MAX);
    localparam int LEN_W    = CNT_W + 1;

    localparam logic [LEN_W-1:0] SLOW_LEN = LEN_W'(SLOW_HALF);
    localparam logic [LEN_W-1:0] FAST_LEN = LEN_W'(FAST_HALF);

    sd_state_e        state_q,    state_d;
    logic [7:0]       tx_q,       tx_d;
    logic [7:0]       rx_q,       rx_d;
    logic [2:0]       bit_q,      bit_d;
    logic [LEN_W-1:0] half_len_q, half_len_d;
    logic [7:0]       rxbyte_q,   rxbyte_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             sclk_q,     sclk_d;
    logic             mosi_q,     mosi_d;

    logic             tick_clear_s;
    logic             half_last_s;

    // Timer only runs while a bit is on the wire; parked at zero otherwise
    always_comb begin
        tick_clear_s = (state_q != ST_LOW) && (state_q != ST_HIGH);
    end

    sd_sclk_tick #(
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) u_tick (
        .clk      (CLKin),
        .rst_n    (Reset),
        .clear    (tick_clear_s),
        .half_len (half_len_q),
        .last     (half_last_s)
    );

    // Next-state and next-output logic for the transfer FSM
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        half_len_d = half_len_q;
        rxbyte_d   = rxbyte_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;

        case (state_q)
            // IDLE and DONE both accept a new byte; DONE does so back-to-back
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d    = ST_LOW;
                    tx_d       = TxByte;
                    bit_d      = 3'd0;
                    half_len_d = Slow ? SLOW_LEN : FAST_LEN;
                    busy_d     = 1'b1;
                    sclk_d     = 1'b0;
                    mosi_d     = TxByte[7];
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = SD_IDLE_MOSI;
                end
            end

            // End of low half: raise SCLK and sample the card
            ST_LOW: begin
                if (half_last_s) begin
                    state_d = ST_HIGH;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], MISO};
                end else begin
                    state_d = ST_LOW;
                end
            end

            // End of high half: either present the next bit or finish
            ST_HIGH: begin
                if (half_last_s) begin
                    sclk_d = 1'b0;
                    if (bit_q == SD_LAST_BIT) begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        rxbyte_d = rx_q;
                        mosi_d   = SD_IDLE_MOSI;
                    end else begin
                        state_d = ST_LOW;
                        tx_d    = {tx_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        mosi_d  = tx_q[6];
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = SD_IDLE_MOSI;
            end
        endcase
    end

    // FSM state, shift registers and registered pin outputs
    always_ff @(posedge CLKin or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            bit_q      <= 3'd0;
            half_len_q <= FAST_LEN;
            rxbyte_q   <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= SD_IDLE_MOSI;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            half_len_q <= half_len_d;
            rxbyte_q   <= rxbyte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign RxByte = rxbyte_q;
    assign SCLK   = sclk_q;
    assign MOSI   = mosi_q;

endmodule

// File: tb/tb_sd_spi_shifter.sv
// Self-checking bench for sd_spi_shifter. A timing model derived from the
// transfer rules (bit index and SCLK phase from the cycle offset since
// Start) predicts Busy/Done/SCLK/MOSI/RxByte on every cycle.
module tb_sd_spi_shifter;

    localparam int SLOW_H = 64;
    localparam int FAST_H = 2;

    logic       CLKin;
    logic       Reset;
    logic       Start;
    logic       Slow;
    logic [7:0] TxByte;
    logic       MISO;
    logic       Busy;
    logic       Done;
    logic [7:0] RxByte;
    logic       SCLK;
    logic       MOSI;

    int         n_chk;
    int         n_fail;
    int         cyc;
    int         sclk_rises;
    int         done_times[$];
    logic [7:0] exp_rx;

    sd_spi_shifter #(
        .SLOW_HALF (SLOW_H),
        .FAST_HALF (FAST_H)
    ) dut (
        .CLKin  (CLKin),
        .Reset  (Reset),
        .Start  (Start),
        .Slow   (Slow),
        .TxByte (TxByte),
        .MISO   (MISO),
        .Busy   (Busy),
        .Done   (Done),
        .RxByte (RxByte),
        .SCLK   (SCLK),
        .MOSI   (MOSI)
    );

    initial begin
        CLKin = 1'b0;
        forever #5 CLKin = ~CLKin;
    end

    // Free-running cycle count, SCLK rise count and Done timestamps
    always @(posedge CLKin) cyc <= cyc + 1;
    always @(posedge SCLK) sclk_rises <= sclk_rises + 1;
    always @(negedge CLKin) if (Done === 1'b1) done_times.push_back(cyc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    // Idle: no activity on the pins, last received byte held
    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLKin);
            check(tag, {20'h0, Busy, Done, SCLK, MOSI, RxByte},
                  {20'h0, 1'b0, 1'b0, 1'b0, 1'b1, exp_rx});
        end
    endtask

    // One transfer, entered at a negedge where the DUT is idle or in DONE.
    // Cycle k=1..16H is the shift window, k=16H+1 is the Done cycle.
    task automatic do_xfer(input logic slow, input logic [7:0] tx, input logic [7:0] pat,
                           input bit loop, input bit disturb, input string tag);
        int         h;
        int         last_k;
        int         idx;
        int         b;
        logic       hi;
        logic [7:0] txv;
        logic [7:0] patv;
        logic [7:0] rx_exp;
        logic [11:0] expv;
        h      = slow ? SLOW_H : FAST_H;
        last_k = 16 * h + 1;
        txv    = tx;
        patv   = pat;
        rx_exp = loop ? tx : pat;
        Start  = 1'b1;
        Slow   = slow;
        TxByte = tx;
        MISO   = loop ? 1'b1 : patv[7];
        for (int k = 1; k <= last_k; k++) begin
            @(negedge CLKin);
            if (k < last_k) begin
                idx  = k - 1;
                b    = idx / (2 * h);
                hi   = ((idx % (2 * h)) >= h);
                expv = {1'b1, 1'b0, hi, txv[7 - b], exp_rx};
            end else begin
                expv = {1'b0, 1'b1, 1'b0, 1'b1, rx_exp};
            end
            check(tag, {20'h0, Busy, Done, SCLK, MOSI, RxByte}, {20'h0, expv});
            if (disturb && (k == 5 || k == 20)) begin
                Start  = 1'b1;
                Slow   = ~Slow;
                TxByte = 8'($urandom);
            end else begin
                Start = 1'b0;
            end
            if (k < last_k) begin
                b    = (k - 1) / (2 * h);
                MISO = loop ? MOSI : patv[7 - b];
            end
        end
        exp_rx = rx_exp;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nd;
        int         r0;
        logic [7:0] r_tx;
        logic [7:0] r_pat;
        logic       r_slow;
        n_chk = 0; n_fail = 0; cyc = 0; sclk_rises = 0;
        Reset = 1'b0; Start = 1'b0; Slow = 1'b0; TxByte = 8'h00; MISO = 1'b0;
        exp_rx = 8'h00;

        // Reset values
        repeat (3) @(negedge CLKin);
        check("reset", {20'h0, Busy, Done, SCLK, MOSI, RxByte}, {20'h0, 4'b0001, 8'h00});
        Reset = 1'b1;

        // Long idle with no Start
        idle_cycles(200, "idle");
        check("idle_no_done", done_times.size(), 0);

        // Reset at cycle 10 of a slow transfer aborts it
        Start = 1'b1; Slow = 1'b1; TxByte = 8'h5A; MISO = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLKin);
            Start = 1'b0;
        end
        check("rst_pre", {30'h0, Busy, MOSI}, {30'h0, 2'b10});
        #2 Reset = 1'b0;
        #1;
        check("rst_abort", {20'h0, Busy, Done, SCLK, MOSI, RxByte}, {20'h0, 4'b0001, 8'h00});
        nd = done_times.size();
        repeat (3) @(negedge CLKin);
        Reset = 1'b1;
        idle_cycles(5, "rst_idle");
        check("rst_no_done", done_times.size(), nd);
        do_xfer(1'b0, 8'hC3, 8'h96, 1'b0, 1'b0, "post_rst");
        idle_cycles(3, "post_rst_idle");

        // Fast loopback A5
        do_xfer(1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, "fast_a5");
        check("fast_a5_rx", RxByte, 8'hA5);
        idle_cycles(4, "fast_a5_idle");

        // Slow FF out, 3C in
        do_xfer(1'b1, 8'hFF, 8'h3C, 1'b0, 1'b0, "slow_ff");
        idle_cycles(4, "slow_ff_idle");

        // Back-to-back 40 then 95
        r0 = sclk_rises;
        nd = done_times.size();
        do_xfer(1'b0, 8'h40, 8'h1E, 1'b0, 1'b0, "b2b_1");
        do_xfer(1'b0, 8'h95, 8'hE7, 1'b0, 1'b0, "b2b_2");
        idle_cycles(2, "b2b_idle");
        check("b2b_rises", sclk_rises - r0, 16);
        check("b2b_dones", done_times.size() - nd, 2);
        if (done_times.size() - nd == 2)
            check("b2b_gap", done_times[nd + 1] - done_times[nd], 33);

        // Starts and Slow toggles mid-transfer are ignored
        nd = done_times.size();
        do_xfer(1'b0, 8'h6B, 8'hD2, 1'b0, 1'b1, "disturb");
        idle_cycles(40, "disturb_idle");
        check("disturb_dones", done_times.size() - nd, 1);

        // Randomized transfers, some chained, some slow
        for (int i = 0; i < 24; i++) begin
            r_tx   = 8'($urandom);
            r_pat  = 8'($urandom);
            r_slow = ($urandom_range(0, 5) == 0);
            do_xfer(r_slow, r_tx, r_pat, 1'($urandom_range(0, 1)),
                    (!r_slow) && ($urandom_range(0, 1) == 1), "rand");
            idle_cycles($urandom_range(0, 3), "rand_idle");
        end
        idle_cycles(5, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
